// File: rtl/rv32i_if_stage.sv
// RV32I instruction fetch stage: issues word fetches to instruction memory,
// buffers in-order responses with their PCs, and hands them to ID.
// Redirects flush the buffer and discard responses already in flight.
package rv32i_if_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_payload_t;
endpackage

module rv32i_if_stage
   import rv32i_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   output logic           imem_req_o,
   output logic [31:0]    imem_addr_o,
   input  logic           imem_gnt_i,
   input  logic           imem_rvalid_i,
   input  logic [31:0]    imem_rdata_i,
   input  logic           redirect_i,
   input  logic [31:0]    redirect_pc_i,
   output logic           if_valid_o,
   input  logic           if_ready_i,
   output if_id_payload_t if_payload_o
);
   localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0]   ALIGN_M  = 32'hFFFF_FFFC;

   // run_q delays the first request to the cycle after reset is seen high
   logic           run_q, run_d;
   logic [31:0]    pc_q, pc_d;           // address of the next new request
   logic           pend_q, pend_d;       // a request is being held awaiting gnt
   logic [31:0]    pend_addr_q, pend_addr_d;
   logic           stale_q, stale_d;     // held request predates a redirect
   logic [CW-1:0]  outst_q, outst_d;     // granted, response not yet seen
   logic [CW-1:0]  disc_q, disc_d;       // responses still to be dropped
   logic [CW-1:0]  fifo_cnt_q, cnt_d;
   logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
   logic [PW-1:0]  aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
   if_id_payload_t fifo_q [FIFO_DEPTH];
   if_id_payload_t fifo_d [FIFO_DEPTH];
   logic [31:0]    aq_q [FIFO_DEPTH];
   logic [31:0]    aq_d [FIFO_DEPTH];

   logic           hs, pop, push, new_req;
   logic [CW:0]    occ;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   // A pop frees a slot this cycle, so it may admit a new request at once;
   // responses come no earlier than next cycle, so the slot is really free.
   assign occ        = (CW+1)'(outst_q) + (CW+1)'(fifo_cnt_q) - (CW+1)'(pop);
   assign new_req    = run_q && rst_ni && !pend_q && !redirect_i && (occ < DEPTH_W);
   assign imem_req_o = (run_q && rst_ni && pend_q) || new_req;
   assign imem_addr_o = pend_q ? pend_addr_q : (pc_q & ALIGN_M);
   assign hs         = imem_req_o && imem_gnt_i;
   assign if_valid_o = rst_ni && (fifo_cnt_q != '0) && !redirect_i;
   assign if_payload_o = if_valid_o ? fifo_q[rd_q] : '0;
   assign pop        = if_valid_o && if_ready_i;
   assign push       = imem_rvalid_i && (disc_q == '0) && !redirect_i;

   // Next-state for fetch PC, request hold, counters, FIFO and address queue
   always_comb begin
      run_d       = 1'b1;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      stale_d     = stale_q;
      disc_d      = disc_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      aq_rd_d     = aq_rd_q;
      aq_wr_d     = aq_wr_q;
      fifo_d      = fifo_q;
      aq_d        = aq_q;
      outst_d     = outst_q + CW'(hs) - CW'(imem_rvalid_i);
      // A new request owns its PC immediately; a held one keeps its address.
      if (new_req) begin
         pc_d = imem_addr_o + 32'd4;
         if (!imem_gnt_i) begin
            pend_d      = 1'b1;
            pend_addr_d = imem_addr_o;
         end
      end
      if (pend_q && imem_gnt_i) begin
         pend_d  = 1'b0;
         stale_d = 1'b0;
      end
      if (imem_rvalid_i && (disc_q != '0)) disc_d = disc_q - CW'(1);
      // A held request that outlived a redirect is dropped when it returns
      if (hs && stale_q) disc_d = disc_d + CW'(1);
      // Address queue tracks every granted request, discarded or not
      if (hs) begin
         aq_d[aq_wr_q] = imem_addr_o;
         aq_wr_d       = nxt(aq_wr_q);
      end
      if (imem_rvalid_i) aq_rd_d = nxt(aq_rd_q);
      if (push) begin
         fifo_d[wr_q].pc    = aq_q[aq_rd_q];
         fifo_d[wr_q].instr = imem_rdata_i;
         wr_d               = nxt(wr_q);
      end
      if (pop) rd_d = nxt(rd_q);
      cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      if (redirect_i) begin
         pc_d    = redirect_pc_i & ALIGN_M;
         stale_d = pend_q && !imem_gnt_i;
         disc_d  = outst_d;
         cnt_d   = '0;
         rd_d    = '0;
         wr_d    = '0;
      end
   end

   // Control state with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         run_q       <= 1'b0;
         pc_q        <= RESET_PC;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         stale_q     <= 1'b0;
         outst_q     <= '0;
         disc_q      <= '0;
         fifo_cnt_q  <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         aq_rd_q     <= '0;
         aq_wr_q     <= '0;
      end else begin
         run_q       <= run_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         stale_q     <= stale_d;
         outst_q     <= outst_d;
         disc_q      <= disc_d;
         fifo_cnt_q  <= cnt_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         aq_rd_q     <= aq_rd_d;
         aq_wr_q     <= aq_wr_d;
      end
   end

   // Buffer storage; contents are qualified by the counters, so no reset
   always_ff @(posedge clk_i) begin
      fifo_q <= fifo_d;
      aq_q   <= aq_d;
   end
endmodule

// File: tb/tb_rv32i_if_stage.sv
// Bench for rv32i_if_stage: directed cycle tables, redirect corner
// sequences, and a randomized run against a reference PC model.
module tb_rv32i_if_stage;
   import rv32i_if_pkg::*;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, gnt, rvalid, redirect, ready;
   logic [31:0]    rdata, rpc, addr, d2_addr;
   logic           req, valid, d2_req, d2_valid;
   if_id_payload_t pl, d2_pl;

   rv32i_if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n), .imem_req_o(req), .imem_addr_o(addr),
      .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .redirect_i(redirect), .redirect_pc_i(rpc), .if_valid_o(valid),
      .if_ready_i(ready), .if_payload_o(pl));

   // Second instance only checks the PC wrap from the top of the space
   rv32i_if_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .imem_req_o(d2_req), .imem_addr_o(d2_addr),
      .imem_gnt_i(d2_req), .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
      .redirect_i(1'b0), .redirect_pc_i(32'h0), .if_valid_o(d2_valid),
      .if_ready_i(1'b1), .if_payload_o(d2_pl));

   typedef struct {
      logic [31:0] a;
      int          due;
   } rsp_t;

   typedef struct {
      bit          rst_n;
      bit          ready;
      bit          ereq;
      logic [31:0] eaddr;
      bit          evalid;
      logic [31:0] epc;
      bit          c2;
      logic [31:0] e2addr;
   } vec_t;

   rsp_t        rq[$];
   int          cyc, gnt_wait, hold_cnt, fix_lat, delivered;
   logic [31:0] hold_addr, exp_pc, prev_addr;
   bit          rnd, sb_on, prev_ng;
   int          total, bad;
   bit          s_req, s_valid, s_d2req, s_d2valid;
   logic [31:0] s_addr, s_pc, s_instr, s_d2addr;
   vec_t        tv[20];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0] ^ 16'hA5C3};
   endfunction

   function automatic vec_t mk(bit r, bit rdy, bit eq, logic [31:0] ea, bit ev,
                               logic [31:0] ep, bit c2 = 1'b0, logic [31:0] e2 = 32'h0);
      vec_t v;
      v.rst_n = r; v.ready = rdy; v.ereq = eq; v.eaddr = ea;
      v.evalid = ev; v.epc = ep; v.c2 = c2; v.e2addr = e2;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock: memory model answers, outputs sampled at the falling edge,
   // running invariants checked, then advance to just after the next edge.
   task automatic step();
      rsp_t r;
      #2;
      gnt = 1'b0;
      if (req) begin
         if (hold_cnt > 0 && addr == hold_addr) hold_cnt--;
         else if (gnt_wait > 0) gnt_wait--;
         else gnt = 1'b1;
      end
      rvalid = 1'b0;
      rdata  = 32'hDEAD_BEEF;
      if (rq.size() > 0) begin
         if (rq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(rq[0].a);
         end
      end
      #2;
      s_req = req; s_addr = addr; s_valid = valid; s_pc = pl.pc; s_instr = pl.instr;
      s_d2req = d2_req; s_d2addr = d2_addr; s_d2valid = d2_valid;
      if (rst_n) begin
         if (prev_ng) begin
            chk("req_hold", 32'(req), 32'd1);
            chk("addr_hold", addr, prev_addr);
         end
         if (!valid) chk("payload_zero", 32'(pl != '0), 32'd0);
         if (redirect) chk("valid_in_redirect", 32'(valid), 32'd0);
         if (rvalid) chk("rvalid_with_full_fifo", 32'(dut.fifo_cnt_q == DEPTH), 32'd0);
         if (sb_on && valid && ready) begin
            chk("sb_pc", pl.pc, exp_pc);
            chk("sb_instr", pl.instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (sb_on && redirect) exp_pc = rpc & 32'hFFFF_FFFC;
      end
      prev_ng   = rst_n && req && !gnt;
      prev_addr = addr;
      if (!rst_n) begin
         rq.delete();
         gnt_wait = 0;
         hold_cnt = 0;
      end else begin
         if (rvalid) void'(rq.pop_front());
         if (gnt) begin
            r.a   = addr;
            r.due = cyc + 1 + (rnd ? int'($urandom_range(0, 4)) : fix_lat);
            rq.push_back(r);
            if (rnd) gnt_wait = $urandom_range(0, 4);
            chk("inflight_limit", 32'(rq.size() > DEPTH), 32'd0);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      gnt    = 1'b0;
      rvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect = 1'b0; ready = 1'b1;
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input string nm, output logic [31:0] pc, output logic [31:0] ins);
      pc = 32'hFFFF_FFFF; ins = 32'hFFFF_FFFF;
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_valid && ready) begin
            pc = s_pc; ins = s_instr;
            return;
         end
      end
      total++; bad++;
      $display("FAIL %s: no payload within 30 cycles", nm);
   endtask

   task automatic wait_req(input string nm, output logic [31:0] a);
      a = 32'hFFFF_FFFF;
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_req) begin
            a = s_addr;
            return;
         end
      end
      total++; bad++;
      $display("FAIL %s: no request within 30 cycles", nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc, ins, a;
      total = 0; bad = 0; cyc = 0; gnt_wait = 0; hold_cnt = 0; fix_lat = 0;
      hold_addr = 32'h0; rnd = 1'b0; sb_on = 1'b0; prev_ng = 1'b0; delivered = 0;
      exp_pc = 32'h0; prev_addr = 32'h0;
      rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; rpc = 32'h0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      @(posedge clk);
      #1;

      // Zero-wait memory, ID always ready: one payload per cycle
      tv[0]  = mk(0, 1, 0, 32'h0,  0, 32'h0);
      tv[1]  = mk(1, 1, 0, 32'h0,  0, 32'h0);
      tv[2]  = mk(1, 1, 1, 32'h0,  0, 32'h0, 1, 32'hFFFF_FFFC);
      tv[3]  = mk(1, 1, 1, 32'h4,  0, 32'h0, 1, 32'h0000_0000);
      tv[4]  = mk(1, 1, 1, 32'h8,  1, 32'h0);
      tv[5]  = mk(1, 1, 1, 32'hC,  1, 32'h4);
      tv[6]  = mk(1, 1, 1, 32'h10, 1, 32'h8);
      tv[7]  = mk(1, 1, 1, 32'h14, 1, 32'hC);
      tv[8]  = mk(1, 1, 1, 32'h18, 1, 32'h10);
      // Reset mid-stream, then ID stalls: FIFO fills, requests stop, head held
      tv[9]  = mk(0, 0, 0, 32'h0,  0, 32'h0);
      tv[10] = mk(1, 0, 0, 32'h0,  0, 32'h0);
      tv[11] = mk(1, 0, 1, 32'h0,  0, 32'h0);
      tv[12] = mk(1, 0, 1, 32'h4,  0, 32'h0);
      tv[13] = mk(1, 0, 0, 32'h0,  1, 32'h0);
      tv[14] = mk(1, 0, 0, 32'h0,  1, 32'h0);
      tv[15] = mk(1, 0, 0, 32'h0,  1, 32'h0);
      tv[16] = mk(1, 0, 0, 32'h0,  1, 32'h0);
      tv[17] = mk(1, 1, 1, 32'h8,  1, 32'h0);
      tv[18] = mk(1, 1, 1, 32'hC,  1, 32'h4);
      tv[19] = mk(1, 1, 1, 32'h10, 1, 32'h8);

      for (int i = 0; i < 20; i++) begin
         rst_n = tv[i].rst_n;
         ready = tv[i].ready;
         step();
         chk($sformatf("t%0d_req", i), 32'(s_req), 32'(tv[i].ereq));
         if (tv[i].ereq) chk($sformatf("t%0d_addr", i), s_addr, tv[i].eaddr);
         chk($sformatf("t%0d_valid", i), 32'(s_valid), 32'(tv[i].evalid));
         if (tv[i].evalid) begin
            chk($sformatf("t%0d_pc", i), s_pc, tv[i].epc);
            chk($sformatf("t%0d_instr", i), s_instr, mem_word(tv[i].epc));
         end
         if (tv[i].c2) begin
            chk($sformatf("t%0d_wrap_req", i), 32'(s_d2req), 32'd1);
            chk($sformatf("t%0d_wrap_addr", i), s_d2addr, tv[i].e2addr);
            chk($sformatf("t%0d_wrap_valid", i), 32'(s_d2valid), 32'd0);
         end
      end

      // Redirect with two requests in flight (one-cycle extra latency)
      fix_lat = 1;
      do_reset();
      step();
      step();
      chk("c_first_addr", s_addr, 32'h0);
      step();
      chk("c_second_addr", s_addr, 32'h4);
      redirect = 1'b1; rpc = 32'h100;
      step();
      redirect = 1'b0;
      chk("c_redir_valid", 32'(s_valid), 32'd0);
      chk("c_redir_req", 32'(s_req), 32'd0);
      wait_valid("c_wait", pc, ins);
      chk("c_pc", pc, 32'h100);
      chk("c_instr", ins, mem_word(32'h100));

      // Gnt withheld at 0x8 across a redirect to 0x200
      fix_lat = 0;
      do_reset();
      hold_addr = 32'h8; hold_cnt = 3;
      step(); step(); step();
      step();
      chk("d_h0_req", 32'(s_req), 32'd1);
      chk("d_h0_addr", s_addr, 32'h8);
      redirect = 1'b1; rpc = 32'h200;
      step();
      redirect = 1'b0;
      chk("d_h1_req", 32'(s_req), 32'd1);
      chk("d_h1_addr", s_addr, 32'h8);
      chk("d_h1_valid", 32'(s_valid), 32'd0);
      step();
      chk("d_h2_addr", s_addr, 32'h8);
      step();
      chk("d_h3_addr", s_addr, 32'h8);
      wait_req("d_next_req", a);
      chk("d_next_addr", a, 32'h200);
      wait_valid("d_wait", pc, ins);
      chk("d_pc", pc, 32'h200);

      // Unaligned redirect target is word-aligned
      do_reset();
      step(); step();
      redirect = 1'b1; rpc = 32'h203;
      step();
      redirect = 1'b0;
      chk("e_redir_req", 32'(s_req), 32'd0);
      wait_req("e_next_req", a);
      chk("e_next_addr", a, 32'h200);
      wait_valid("e_wait", pc, ins);
      chk("e_pc", pc, 32'h200);
      chk("e_instr", ins, mem_word(32'h200));

      // Random delays, stalls and redirects against the reference PC model
      rnd = 1'b1;
      do_reset();
      exp_pc = 32'h0; delivered = 0; sb_on = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ready    = ($urandom_range(0, 9) < 7);
         redirect = ($urandom_range(0, 24) == 0);
         rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
         step();
      end
      redirect = 1'b0;
      sb_on = 1'b0;
      chk("f_progress", 32'(delivered > 200), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rv32i_if_stage.md
RV32I_IF_STAGE -- requirements
Module: rv32i_if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving fetch-buffer entries and the in-flight limit; legal values are 2..8.
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni  input  1  synchronous active-low reset, sampled on the clk_i rising edge.
REQ-005 The block SHALL have port imem_req_o  output  1  instruction memory request.
REQ-006 The block SHALL have port imem_addr_o  output  32  word-aligned fetch address.
REQ-007 The block SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-008 The block SHALL have port imem_rvalid_i  input  1  response valid; in order; no earlier than the cycle after the matching gnt.
REQ-009 The block SHALL have port imem_rdata_i  input  32  instruction word.
REQ-010 The block SHALL have port redirect_i  input  1  control-flow change from EX; overrides all other activity.
REQ-011 The block SHALL have port redirect_pc_i  input  32  redirect target.
REQ-012 The block SHALL have port if_valid_o  output  1  payload valid toward ID.
REQ-013 The block SHALL have port if_ready_i  input  1  ID accepts the payload; low means stall.
REQ-014 The block SHALL have port if_payload_o  output  if_id_payload_t  fields pc and instr of the buffer head.

Function
REQ-015 The block SHALL keep a fetch PC register; each imem handshake (req && gnt) SHALL advance it by 4, with 32-bit wrap (32'hFFFF_FFFC -> 32'h0).
REQ-016 The block SHALL drive imem_addr_o from the fetch PC with bits [1:0] forced to 0.
REQ-017 The block SHALL assert imem_req_o only when outstanding + buffered < FIFO_DEPTH, so that every response always has a free buffer entry.
REQ-018 Once imem_req_o is asserted, the block SHALL hold imem_req_o and imem_addr_o stable until imem_gnt_i, including through redirect and stall.
REQ-019 The block SHALL count outstanding requests (0..FIFO_DEPTH): +1 on handshake, -1 on imem_rvalid_i, net 0 when both occur in one cycle.
REQ-020 Each accepted response SHALL push {pc, instr} into an in-order FIFO; the pc SHALL be the address of the matching request, held in a parallel in-flight address queue.
REQ-021 The block SHALL drive if_valid_o = FIFO not empty && !redirect_i, with if_payload_o = FIFO head; when if_valid_o is low, if_payload_o SHALL be '0.
REQ-022 The FIFO SHALL pop only on if_valid_o && if_ready_i; payload SHALL hold stable while if_valid_o && !if_ready_i.
REQ-023 A push and a pop in the same cycle SHALL both take effect, with the count unchanged, including when the FIFO is full.
REQ-024 Fetch-to-ID latency SHALL be one cycle after imem_rvalid_i when the FIFO is empty, with no combinational path from imem_rdata_i to if_payload_o.
REQ-025 On redirect_i, the block SHALL at the next edge: load the fetch PC with {redirect_pc_i[31:2],2'b00}; flush the FIFO; load a discard counter with the number of in-flight requests, plus one if a request is granted in that same cycle.
REQ-026 If imem_req_o is asserted but not granted when redirect_i occurs, that request SHALL stay pending and counted; when it is granted, its response SHALL be discarded and fetch SHALL then resume at the redirect PC.
REQ-027 While the discard counter is nonzero, each imem_rvalid_i SHALL decrement it and SHALL NOT be pushed.
REQ-028 A redirect arriving while discarding SHALL reload the discard counter with the current in-flight total; the most recent redirect SHALL take priority.
REQ-029 In a redirect cycle the block SHALL perform no pop and SHALL start no new request.

Reset
REQ-030 While rst_ni is low, the block SHALL hold: fetch PC = RESET_PC, FIFO empty, outstanding = 0, discard = 0, imem_req_o = 0, if_valid_o = 0, if_payload_o = '0.
REQ-031 The first request SHALL be issued in the first cycle after rst_ni is sampled high, with imem_addr_o = RESET_PC.
REQ-032 Reset mid-transaction SHALL abandon all in-flight state; the bench SHALL also reset the imem model.

Verification
REQ-033 Scenario: reset, then zero-wait memory (gnt same cycle, rvalid next cycle), if_ready_i = 1 -> one payload per cycle from steady state, pc 0x0, 0x4, 0x8, ..., with instr matching memory.
REQ-034 Scenario: if_ready_i = 0 for 5 cycles -> FIFO fills to 2, imem_req_o drops, payload pc 0x0 is held; on release, 0x0 and 0x4 drain with no loss or duplication.
REQ-035 Scenario: with 2 requests in flight, redirect_i with redirect_pc_i = 0x100 -> both responses dropped, if_valid_o low in the redirect cycle, next payload pc = 0x100.
REQ-036 Scenario: memory withholds gnt 3 cycles at addr 0x8 while redirect_pc_i = 0x200 -> addr 0x8 held until gnt, its response discarded, next request 0x200.
REQ-037 Scenario: redirect_pc_i = 0x203 -> imem_addr_o = 0x200; RESET_PC = 0xFFFF_FFFC -> second request at 0x0000_0000.
REQ-038 Scenario: random gnt/rvalid delays of 0-4 cycles, random stalls and redirects -> delivered pc sequence matches a reference PC model; the bench checks that no rvalid ever arrives with a full FIFO.
